// File: rtl/sdram_frame_writer.sv
// Avalon-MM burst write master: buffers a valid/ready stream and writes one frame to SDRAM in fixed bursts.
// Optional macro SDRAM_WRITER_STATS_EN adds stall_cycles_o (write cycles stalled by waitrequest).
`timescale 1ns/1ps
module sdram_frame_writer #(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 29,
   parameter int BURST_LEN  = 16,
   parameter int FIFO_DEPTH = 64,
   parameter int LEN_W      = 24
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic [ADDR_W-1:0]   base_addr_i,
   input  logic [LEN_W-1:0]    frame_words_i,
   output logic                busy_o,
   output logic                done_o,
   input  logic [DATA_W-1:0]   st_data_i,
   input  logic                st_valid_i,
   output logic                st_ready_o,
   output logic [ADDR_W-1:0]   sdram_address_o,
   output logic [7:0]          sdram_burstcount_o,
   output logic [DATA_W-1:0]   sdram_writedata_o,
   output logic [DATA_W/8-1:0] sdram_byteenable_o,
   output logic                sdram_write_o,
   input  logic                sdram_waitrequest_i
`ifdef SDRAM_WRITER_STATS_EN
   ,
   output logic [31:0]         stall_cycles_o
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [LEN_W-1:0] BURST_LEN_L = LEN_W'(BURST_LEN);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_BURST, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  frame_len_q, frame_len_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;
   logic [LEN_W-1:0]  accepted_q, accepted_d;
   logic [7:0]        burst_len_q, burst_len_d;
   logic [7:0]        beats_left_q, beats_left_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

   logic             fifo_full;
   logic             push;
   logic             pop;
   logic             start_ok;
   logic             beat_ok;
   logic             last_beat;
   logic [LEN_W-1:0] cur_len;
   logic [LEN_W-1:0] burst_len_ext;

   assign fifo_full     = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = (state_q == S_DONE);
   assign st_ready_o    = busy_o && !fifo_full && (accepted_q < frame_len_q);
   assign push          = st_valid_i && st_ready_o;
   assign sdram_write_o = (state_q == S_BURST);
   assign beat_ok       = sdram_write_o && !sdram_waitrequest_i;
   assign pop           = beat_ok;
   assign last_beat     = beat_ok && (beats_left_q == 8'd1);
   assign start_ok      = (state_q == S_IDLE) && start_i;
   assign cur_len       = (remaining_q < BURST_LEN_L) ? remaining_q : BURST_LEN_L;
   assign burst_len_ext = LEN_W'(burst_len_q);

   // Show-ahead FIFO head drives the bus directly; gated to zero outside a burst.
   assign sdram_address_o    = addr_q;
   assign sdram_burstcount_o = burst_len_q;
   assign sdram_writedata_o  = sdram_write_o ? mem_q[rd_ptr_q] : '0;
   assign sdram_byteenable_o = sdram_write_o ? '1 : '0;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      frame_len_d  = frame_len_q;
      remaining_d  = remaining_q;
      accepted_d   = accepted_q;
      burst_len_d  = burst_len_q;
      beats_left_d = beats_left_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               frame_len_d = frame_words_i;
               remaining_d = frame_words_i;
               accepted_d  = '0;
               addr_d      = base_addr_i;
               state_d     = (frame_words_i == '0) ? S_DONE : S_FILL;
            end
         end
         S_FILL: begin
            // Whole burst must already be buffered so write never bubbles.
            if (LEN_W'(fifo_cnt_q) >= cur_len) begin
               state_d      = S_BURST;
               burst_len_d  = cur_len[7:0];
               beats_left_d = cur_len[7:0];
            end
         end
         S_BURST: begin
            if (beat_ok) begin
               beats_left_d = beats_left_q - 8'd1;
            end
            if (last_beat) begin
               addr_d      = addr_q + ADDR_W'(burst_len_q);
               remaining_d = remaining_q - burst_len_ext;
               state_d     = (remaining_q == burst_len_ext) ? S_DONE : S_FILL;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (push) begin
         accepted_d = accepted_q + LEN_W'(1);
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
         fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         frame_len_q  <= '0;
         remaining_q  <= '0;
         accepted_q   <= '0;
         burst_len_q  <= '0;
         beats_left_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         frame_len_q  <= frame_len_d;
         remaining_q  <= remaining_d;
         accepted_q   <= accepted_d;
         burst_len_q  <= burst_len_d;
         beats_left_q <= beats_left_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fifo_cnt_q   <= fifo_cnt_d;
      end
   end

   // Storage is not reset; emptiness is defined by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= st_data_i;
      end
   end

`ifdef SDRAM_WRITER_STATS_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (start_ok) begin
         stall_d = '0;
      end else if (sdram_write_o && sdram_waitrequest_i && (stall_q != '1)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles_o = stall_q;
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Directed bench for sdram_frame_writer: table of frame scenarios plus hand sequences for len 0 and mid-burst reset.
`timescale 1ns/1ps
module tb_sdram_frame_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [28:0] base_addr_i = '0;
   logic [23:0] frame_words_i = '0;
   logic        busy_o;
   logic        done_o;
   logic [63:0] st_data_i = '0;
   logic        st_valid_i = 1'b0;
   logic        st_ready_o;
   logic [28:0] sdram_address_o;
   logic [7:0]  sdram_burstcount_o;
   logic [63:0] sdram_writedata_o;
   logic [7:0]  sdram_byteenable_o;
   logic        sdram_write_o;
   logic        sdram_waitrequest_i = 1'b0;
`ifdef SDRAM_WRITER_STATS_EN
   logic [31:0] stall_cycles_o;
`endif

   sdram_frame_writer dut (
      .clk                 (clk),
      .rst                 (rst),
      .start_i             (start_i),
      .base_addr_i         (base_addr_i),
      .frame_words_i       (frame_words_i),
      .busy_o              (busy_o),
      .done_o              (done_o),
      .st_data_i           (st_data_i),
      .st_valid_i          (st_valid_i),
      .st_ready_o          (st_ready_o),
      .sdram_address_o     (sdram_address_o),
      .sdram_burstcount_o  (sdram_burstcount_o),
      .sdram_writedata_o   (sdram_writedata_o),
      .sdram_byteenable_o  (sdram_byteenable_o),
      .sdram_write_o       (sdram_write_o),
      .sdram_waitrequest_i (sdram_waitrequest_i)
`ifdef SDRAM_WRITER_STATS_EN
      ,
      .stall_cycles_o      (stall_cycles_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [28:0] base;
      int          len;
      int          valid_every;
      int          wait_max;
      int          exp_bursts;
      int          exp_last_bc;
      logic [28:0] exp_last_addr;
   } vec_t;

   vec_t vecs[6];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mk(input int v, input int i);
      return {32'(v), 32'(i)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input vec_t v, input int vidx);
      int          sent = 0;
      int          written = 0;
      int          bursts = 0;
      int          beat = 0;
      int          stall_left = -1;
      int          injected = 0;
      int          last_bc = 0;
      int          exp_bc;
      int          bc_cur = 0;
      logic [28:0] addr_cur = '0;
      logic [28:0] exp_addr;
      logic        finished = 1'b0;
      logic        wq;

      base_addr_i   = v.base;
      frame_words_i = 24'(v.len);
      start_i       = 1'b1;
      tick();
      check("busy_after_start", busy_o, 1);
      for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
         // Second start while busy must be ignored.
         if (cyc == 3) begin
            start_i       = 1'b1;
            base_addr_i   = 29'h7000;
            frame_words_i = 24'd3;
         end else begin
            start_i = 1'b0;
         end
         st_valid_i = ((cyc % v.valid_every) == 0);
         st_data_i  = mk(vidx, sent);
         if (sent >= v.len) check("ready_after_len", st_ready_o, 0);
         wq = 1'b0;
         if (sdram_write_o) begin
            if (beat == 0 && stall_left < 0) begin
               exp_bc   = (v.len - written < 16) ? v.len - written : 16;
               exp_addr = v.base + 29'(16 * bursts);
               check("burst_count", sdram_burstcount_o, exp_bc);
               check("burst_addr", sdram_address_o, exp_addr);
               check("burst_prefilled", (sent - written) >= exp_bc, 1);
               bc_cur   = int'(sdram_burstcount_o);
               addr_cur = sdram_address_o;
            end else begin
               check("addr_stable", sdram_address_o, addr_cur);
               check("bc_stable", sdram_burstcount_o, bc_cur);
            end
            check("byteenable", sdram_byteenable_o, 8'hFF);
            if (stall_left < 0) stall_left = (v.wait_max == 0) ? 0 : ((written * 7 + 3) % (v.wait_max + 1));
            check("writedata", sdram_writedata_o, mk(vidx, written));
            if (stall_left > 0) begin
               wq = 1'b1;
               stall_left--;
               injected++;
            end else begin
               written++;
               beat++;
               stall_left = -1;
               if (beat == bc_cur) begin
                  bursts++;
                  last_bc = bc_cur;
                  beat    = 0;
               end
            end
         end else if (beat != 0) begin
            check("write_held_in_burst", sdram_write_o, 1);
         end
         if (st_valid_i && st_ready_o) sent++;
         sdram_waitrequest_i = wq;
         if (done_o) begin
            start_i  = 1'b1;
            finished = 1'b1;
         end
         tick();
      end
      start_i             = 1'b0;
      st_valid_i          = 1'b0;
      sdram_waitrequest_i = 1'b0;
      check("frame_done_seen", finished, 1);
      check("words_accepted", sent, v.len);
      check("beats_written", written, v.len);
      check("burst_total", bursts, v.exp_bursts);
      check("last_burst_len", last_bc, v.exp_last_bc);
      check("last_burst_addr", addr_cur, v.exp_last_addr);
`ifdef SDRAM_WRITER_STATS_EN
      check("stall_cycles", stall_cycles_o, injected);
`endif
      for (int k = 0; k < 3; k++) begin
         check("idle_busy", busy_o, 0);
         check("idle_done", done_o, 0);
         check("idle_write", sdram_write_o, 0);
         tick();
      end
   endtask

   initial begin
      int   dones;
      int   writes;
      int   beats;
      logic hit;
      vec_t vpost;

      vecs[0] = '{29'h100,      32, 1, 0, 2, 16, 29'h110};
      vecs[1] = '{29'h100,      20, 1, 0, 2, 4,  29'h110};
      vecs[2] = '{29'h300,      40, 1, 5, 3, 8,  29'h320};
      vecs[3] = '{29'h100,      16, 3, 0, 1, 16, 29'h100};
      vecs[4] = '{29'h1FFFFFF8, 24, 1, 2, 2, 8,  29'h008};
      vecs[5] = '{29'h000,      1,  2, 1, 1, 1,  29'h000};

      repeat (3) tick();
      check("rst_write", sdram_write_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_ready", st_ready_o, 0);
      check("rst_byteenable", sdram_byteenable_o, 0);
      check("rst_burstcount", sdram_burstcount_o, 0);
      check("rst_address", sdram_address_o, 0);
      check("rst_writedata", sdram_writedata_o, 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

      // Zero-length frame: one done pulse, no write.
      base_addr_i   = 29'h50;
      frame_words_i = 24'd0;
      start_i       = 1'b1;
      tick();
      start_i = 1'b0;
      dones   = 0;
      writes  = 0;
      for (int k = 0; k < 4; k++) begin
         if (done_o) dones++;
         if (sdram_write_o) writes++;
         tick();
      end
      check("len0_done_pulses", dones, 1);
      check("len0_writes", writes, 0);
      check("len0_busy_end", busy_o, 0);

      // Asynchronous reset in the middle of a burst.
      base_addr_i   = 29'h400;
      frame_words_i = 24'd32;
      start_i       = 1'b1;
      tick();
      start_i    = 1'b0;
      st_valid_i = 1'b1;
      beats      = 0;
      hit        = 1'b0;
      for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
         st_data_i = 64'(cyc);
         if (sdram_write_o && beats == 7) begin
            hit = 1'b1;
         end else begin
            if (sdram_write_o) beats++;
            tick();
         end
      end
      check("reach_beat7", hit, 1);
      rst = 1'b1;
      #1;
      check("rst_mid_write", sdram_write_o, 0);
      check("rst_mid_busy", busy_o, 0);
      check("rst_mid_ready", st_ready_o, 0);
      check("rst_mid_byteenable", sdram_byteenable_o, 0);
      st_valid_i = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      vpost = '{29'h200, 16, 1, 0, 1, 16, 29'h200};
      run_frame(vpost, 9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
